// File: rtl/dpm_pkg.sv
// Shared types and constants for the DPM tile scheduler and its raster counter.
package dpm_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_START,
      S_RUN,
      S_NEXT,
      S_DONE
   } sched_state_t;

   localparam int GROUP_ROWS_DFLT = 4;

   function automatic int out_per_tile(input int group_rows);
      return group_rows * group_rows;
   endfunction

   localparam int OUT_PER_TILE = out_per_tile(GROUP_ROWS_DFLT);

   // Index width for a counter over n values; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dpm_tile_sched_raster.sv
// tile_raster_cnt: raster-order tile index counter (x fastest) with clear, increment and last flag.
module tile_raster_cnt
   import dpm_pkg::*;
#(
   parameter int NX = 4,
   parameter int NY = 4,
   localparam int XW = idx_w(NX),
   localparam int YW = idx_w(NY)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);

   logic x_last;
   logic y_last;

   assign x_last = (x == XW'(NX - 1));
   assign y_last = (y == YW'(NY - 1));
   assign last   = x_last && y_last;

   // Incrementing past the final tile wraps to (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (inc) begin
         if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dpm_tile_sched.sv
// Raster tile scheduler for the DPM: prefetch request, DPM start, beat counting, frame done.
// Optional watchdog on missing DPM beats is built with DPM_SCHED_WDOG_EN.
module dpm_tile_sched
   import dpm_pkg::*;
#(
   parameter int TILES_X     = 4,
   parameter int TILES_Y     = 4,
   parameter int GROUP_ROWS  = 4,
   parameter int TILE_STRIDE = 4,
   parameter int COORD_W     = 12,
   parameter int WDOG_CYC    = 4096,
   localparam int XW = idx_w(TILES_X),
   localparam int YW = idx_w(TILES_Y)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               abort,
   output logic               pf_req,
   output logic [COORD_W-1:0] pf_x,
   output logic [COORD_W-1:0] pf_y,
   input  logic               pf_ack,
   output logic               dpm_start,
   input  logic               dpm_out_valid,
   output logic [XW-1:0]      tile_x,
   output logic [YW-1:0]      tile_y,
   output logic               busy,
   output logic               frame_done,
   output logic               err
);

   localparam int OUT_TILE = out_per_tile(GROUP_ROWS);
   localparam int BW       = $clog2(OUT_TILE + 1);

   sched_state_t  state, state_nxt;
   logic [BW-1:0] beat_cnt, beat_nxt;
   logic          t_clr, t_inc, t_last;

   tile_raster_cnt #(
      .NX(TILES_X),
      .NY(TILES_Y)
   ) u_raster (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (t_clr),
      .inc  (t_inc),
      .x    (tile_x),
      .y    (tile_y),
      .last (t_last)
   );

`ifdef DPM_SCHED_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);

   logic [WW-1:0] wdog_cnt;
   logic          err_q, err_nxt;
   logic          wdog_hit;

   // Zero outside RUN, so every entry to RUN starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            wdog_cnt <= '0;
      else if (state != S_RUN || dpm_out_valid) wdog_cnt <= '0;
      else                                   wdog_cnt <= wdog_cnt + 1'b1;
   end

   assign wdog_hit = (wdog_cnt == WW'(WDOG_CYC - 1)) && !dpm_out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_nxt;
   end

   assign err = err_q;
`else
   // The limit only matters when the watchdog is built.
   logic unused_wdog_cyc;
   assign unused_wdog_cyc = ^WDOG_CYC;
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat_cnt;
      t_clr     = 1'b0;
      t_inc     = 1'b0;
`ifdef DPM_SCHED_WDOG_EN
      err_nxt   = err_q;
`endif
      if (abort) begin
         state_nxt = S_IDLE;
         beat_nxt  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  t_clr     = 1'b1;
                  beat_nxt  = '0;
                  state_nxt = S_REQ;
`ifdef DPM_SCHED_WDOG_EN
                  err_nxt   = 1'b0;
`endif
               end
            end
            S_REQ:   if (pf_ack) state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN: begin
               if (dpm_out_valid) begin
                  if (beat_cnt == BW'(OUT_TILE - 1)) begin
                     beat_nxt  = '0;
                     state_nxt = S_NEXT;
                  end else begin
                     beat_nxt  = beat_cnt + 1'b1;
                  end
               end
`ifdef DPM_SCHED_WDOG_EN
               else if (wdog_hit) begin
                  beat_nxt  = '0;
                  err_nxt   = 1'b1;
                  state_nxt = S_IDLE;
               end
`endif
            end
            // last is sampled before the increment lands, i.e. for the tile just finished.
            S_NEXT: begin
               t_inc     = 1'b1;
               state_nxt = t_last ? S_DONE : S_REQ;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign pf_req     = (state == S_REQ);
   assign dpm_start  = (state == S_START);
   assign frame_done = (state == S_DONE);
   assign busy       = (state != S_IDLE);
   assign pf_x       = COORD_W'(32'(tile_x) * 32'(TILE_STRIDE));
   assign pf_y       = COORD_W'(32'(tile_y) * 32'(TILE_STRIDE));

endmodule

// File: tb/tb_dpm_tile_sched.sv
// Directed/randomized bench for dpm_tile_sched on a 2x2 frame with a raster-order reference model.
module tb_dpm_tile_sched;

   localparam int TX   = 2;
   localparam int TY   = 2;
   localparam int GR   = 4;
   localparam int STR  = 4;
   localparam int CW   = 12;
   localparam int WDOG = 32;
   localparam int OUT  = GR * GR;

   logic          clk, rst_n;
   logic          frame_start, abort, pf_ack, dpm_out_valid;
   logic          pf_req, dpm_start, busy, frame_done, err;
   logic [CW-1:0] pf_x, pf_y;
   logic [0:0]    tile_x, tile_y;

   int n_chk  = 0;
   int n_fail = 0;
   int n_start = 0;
   int n_done  = 0;

   dpm_tile_sched #(
      .TILES_X(TX), .TILES_Y(TY), .GROUP_ROWS(GR), .TILE_STRIDE(STR),
      .COORD_W(CW), .WDOG_CYC(WDOG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
      .pf_req(pf_req), .pf_x(pf_x), .pf_y(pf_y), .pf_ack(pf_ack),
      .dpm_start(dpm_start), .dpm_out_valid(dpm_out_valid),
      .tile_x(tile_x), .tile_y(tile_y), .busy(busy),
      .frame_done(frame_done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dpm_start)  n_start++;
      if (frame_done) n_done++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One whole frame. ack_dly<0 picks a random ack delay per tile; gaps inserts idle
   // cycles between beats; noisy re-pulses frame_start throughout (must be ignored).
   task automatic run_frame(input int ack_dly, input bit gaps, input bit noisy);
      int s0 = n_start;
      int d0 = n_done;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int t = 0; t < TX * TY; t++) begin
         int ex  = t % TX;
         int ey  = t / TX;
         int dly = (ack_dly < 0) ? int'($urandom_range(0, 4)) : ack_dly;
         chk("pf_req_up", pf_req, 1);
         chk("pf_x", pf_x, ex * STR);
         chk("pf_y", pf_y, ey * STR);
         chk("tile_xy", {tile_y, tile_x}, {ey[0], ex[0]});
         for (int i = 0; i < dly; i++) begin
            dpm_out_valid = 1'($urandom_range(0, 1));
            frame_start   = noisy;
            step();
            chk("pf_req_hold", pf_req, 1);
            chk("pf_xy_hold", {pf_y, pf_x}, {12'(ey * STR), 12'(ex * STR)});
            chk("no_start_in_req", dpm_start, 0);
         end
         dpm_out_valid = 1'b0;
         frame_start   = 1'b0;
         pf_ack = 1'b1;
         step();
         pf_ack = 1'b0;
         chk("dpm_start", dpm_start, 1);
         chk("pf_req_drop", pf_req, 0);
         step();
         chk("dpm_start_1cyc", dpm_start, 0);
         for (int b = 0; b < OUT; b++) begin
            if (gaps) begin
               int g = int'($urandom_range(0, 2));
               for (int k = 0; k < g; k++) begin
                  frame_start = noisy;
                  step();
               end
            end
            dpm_out_valid = 1'b1;
            frame_start   = noisy;
            step();
            dpm_out_valid = 1'b0;
            frame_start   = 1'b0;
         end
         chk("next_quiet", {pf_req, dpm_start, frame_done, busy}, 4'b0001);
         step();
         if (t == TX * TY - 1) chk("frame_done_lat", frame_done, 1);
      end
      step();
      chk("frame_done_1cyc", frame_done, 0);
      chk("idle_busy", busy, 0);
      chk("start_count", n_start - s0, TX * TY);
      chk("done_count", n_done - d0, 1);
      chk("err_clear", err, 0);
   endtask

   initial begin
      int d0;
      rst_n = 1'b0;
      frame_start = 1'b0;
      abort = 1'b0;
      pf_ack = 1'b0;
      dpm_out_valid = 1'b0;
      #12;
      chk("rst_outs", {pf_req, dpm_start, busy, frame_done, err}, 0);
      chk("rst_coords", {pf_x, pf_y, tile_x, tile_y}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("idle_after_rst", busy, 0);

      // Nominal frame: immediate ack, back-to-back beats.
      run_frame(0, 1'b0, 1'b0);

      // Delayed ack on every tile.
      run_frame(5, 1'b0, 1'b0);

      // Stray beats while idle must not pre-load the beat counter.
      for (int i = 0; i < 3; i++) begin
         dpm_out_valid = 1'b1;
         step();
         dpm_out_valid = 1'b0;
         step();
      end
      chk("stray_idle", busy, 0);
      run_frame(-1, 1'b1, 1'b0);

      // Abort mid-tile after 7 beats.
      d0 = n_done;
      frame_start = 1'b1; step(); frame_start = 1'b0;
      pf_ack = 1'b1; step(); pf_ack = 1'b0;
      step();
      for (int b = 0; b < 7; b++) begin
         dpm_out_valid = 1'b1; step(); dpm_out_valid = 1'b0;
      end
      abort = 1'b1;
      dpm_out_valid = 1'b1;
      step();
      abort = 1'b0;
      dpm_out_valid = 1'b0;
      chk("abort_idle", {busy, pf_req, dpm_start}, 0);
      repeat (4) step();
      chk("abort_no_done", n_done - d0, 0);
      run_frame(-1, 1'b1, 1'b0);

      // Abort while a request is pending drops pf_req without an ack.
      frame_start = 1'b1; step(); frame_start = 1'b0;
      chk("req_before_abort", pf_req, 1);
      abort = 1'b1; pf_ack = 1'b1; step(); abort = 1'b0; pf_ack = 1'b0;
      chk("abort_req", {pf_req, dpm_start, busy}, 0);

      // frame_start together with abort in IDLE stays idle.
      frame_start = 1'b1; abort = 1'b1; step(); frame_start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", {busy, pf_req}, 0);

      // Repeated frame_start during a frame is ignored.
      run_frame(-1, 1'b1, 1'b1);

`ifdef DPM_SCHED_WDOG_EN
      frame_start = 1'b1; step(); frame_start = 1'b0;
      pf_ack = 1'b1; step(); pf_ack = 1'b0;
      step();
      d0 = n_done;
      repeat (WDOG - 1) step();
      chk("wdog_pre", {busy, err}, 2'b10);
      step();
      chk("wdog_fire", {busy, err}, 2'b01);
      chk("wdog_no_done", n_done - d0, 0);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      chk("wdog_err_clr", {busy, err}, 2'b10);
      abort = 1'b1; step(); abort = 1'b0;
`else
      frame_start = 1'b1; step(); frame_start = 1'b0;
      pf_ack = 1'b1; step(); pf_ack = 1'b0;
      repeat (WDOG + 8) step();
      chk("run_waits", {busy, err}, 2'b10);
      abort = 1'b1; step(); abort = 1'b0;
`endif
      chk("final_idle", busy, 0);
      run_frame(0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dpm_tile_sched.md
# dpm_tile_sched

Tile scheduler that sequences the deformable processing module (DPM) across a frame. For each output tile, in raster order, it issues a reference-tile fetch request to the split prefetcher, pulses the DPM start, and counts the DPM's per-tile output beats. It then advances to the next tile and flags frame completion. It sits between the frame-level control register block and the dpm/prefetcher pair.

## Interface
- TILES_X, 4: tiles per frame row
- TILES_Y, 4: tile rows per frame
- GROUP_ROWS, 4: tile edge in output pixels; outputs per tile = GROUP_ROWS*GROUP_ROWS
- TILE_STRIDE, 4: reference-frame pixel step between adjacent tile origins
- COORD_W, 12: width of prefetch coordinates
- WDOG_CYC, 4096: watchdog limit in cycles (used only with DPM_SCHED_WDOG_EN)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse that launches a frame; honoured only in IDLE
- abort  in  1  synchronous abort; highest priority
- pf_req  out  1  reference-tile fetch request; held until accepted
- pf_x, pf_y  out  COORD_W  tile origin: tile_x*TILE_STRIDE, tile_y*TILE_STRIDE; stable while pf_req=1
- pf_ack  in  1  prefetcher accepts the request when pf_req&&pf_ack
- dpm_start  out  1  one-cycle start pulse to the DPM
- dpm_out_valid  in  1  DPM output beat
- tile_x, tile_y  out  $clog2 widths (min 1)  current tile index
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last tile completes
- err  out  1  sticky watchdog error, cleared by frame_start (always 0 without the macro)

## Operation
- States: IDLE, REQ, START, RUN, NEXT, DONE.
- IDLE: when frame_start=1, clear tile_x, tile_y and beat_cnt and go to REQ.
- REQ: drive pf_req=1 with the current coordinates. On pf_ack, go to START.
- START: drive dpm_start=1 for exactly one cycle, then go to RUN.
- RUN: each dpm_out_valid increments beat_cnt. The beat that brings the count to GROUP_ROWS*GROUP_ROWS clears beat_cnt and moves to NEXT.
- NEXT: if tile_x==TILES_X-1, set tile_x to 0 and increment tile_y; otherwise increment tile_x. If the last tile (TILES_X-1, TILES_Y-1) has just finished, go to DONE; otherwise go to REQ.
- DONE: drive frame_done=1 for one cycle, then go to IDLE.
- abort in any state: go to IDLE on the next edge, deassert pf_req and dpm_start, clear beat_cnt, no frame_done. abort wins over every other event in the same cycle.
- dpm_out_valid outside RUN is ignored and does not increment beat_cnt.
- frame_start outside IDLE is ignored.
- frame_start and abort in the same cycle while in IDLE: stay in IDLE.
- Coordinates are computed as unsigned products truncated to COORD_W.

## Timing
- Reset values: every output is 0, state is IDLE, all counters are 0.
- Latency from frame_start to pf_req: 1 cycle.
- Latency from pf_ack to dpm_start: 1 cycle (dpm_start is high the cycle after the ack).
- Latency from the final beat of a tile to the next pf_req: 2 cycles (RUN→NEXT→REQ).
- Latency from the last beat of the frame to frame_done: 2 cycles.
- pf_req is registered and never drops without an ack, except on abort.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- DPM_SCHED_WDOG_EN defined:
  - A counter runs in RUN and resets on every dpm_out_valid.
  - When it reaches WDOG_CYC, set err=1 and go to IDLE with no frame_done.
  - The counter is also cleared on entry to RUN.
- DPM_SCHED_WDOG_EN undefined: no counter is built, err is tied to 0, and RUN waits indefinitely.

## Structure
- Shared package dpm_pkg holds:
  - the state enum type sched_state_t;
  - localparam OUT_PER_TILE = GROUP_ROWS*GROUP_ROWS.
- One sub-module, tile_raster_cnt: the tile_x/tile_y wrap counter with increment, clear and last outputs, which is reusable by the prefetcher.
- Everything else is a single always_ff FSM.

## Test plan
- Nominal 2x2 frame (TILES_X=TILES_Y=2), pf_ack immediate, 16 beats per tile:
  - 4 pf_req handshakes with (pf_x,pf_y) = (0,0),(4,0),(0,4),(4,4);
  - 4 dpm_start pulses;
  - frame_done exactly 2 cycles after the 64th beat.
- pf_ack delayed 5 cycles: pf_req stays high and coordinates stay stable for 5 cycles; dpm_start follows the ack by 1 cycle.
- Stray beats: 3 dpm_out_valid pulses in IDLE, then a frame → beat counting is unaffected and frame_done occurs on schedule.
- Abort in RUN after 7 beats: IDLE next cycle, busy=0, no frame_done. A new frame_start restarts at tile (0,0).
- frame_start repeated mid-frame → ignored; tile sequence and frame_done are unchanged.
- With DPM_SCHED_WDOG_EN and WDOG_CYC=32: withhold beats after dpm_start → err=1 after 32 cycles, state IDLE. The next frame_start clears err.
